// File: rtl/wb_dmem_arbiter.sv
// rtl/wb_dmem_arbiter.sv - two-master round-robin Wishbone arbiter for a shared data memory with bus timeout
module wb_dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,

    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    // last_grant: 0 = m0 was granted last, 1 = m1 was granted last.
    // It also names the master a DRAIN is waiting on, since the
    // timed-out owner is always the most recent grant.
    logic        last_grant_q, last_grant_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic            owning;
    logic            owner_is_m1;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [DW/8-1:0] own_sel;
    logic            own_we;
    logic            own_cyc;
    logic            own_stb;
    logic            stall;
    logic            bus_timeout;
    logic            drain_cyc;

    assign owning      = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign owner_is_m1 = (state_q == ST_OWN1);

    // Select the request of whichever master currently owns the bus
    always_comb begin
        if (owner_is_m1) begin
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
            own_sel = m1_sel_i;
            own_we  = m1_we_i;
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
        end else begin
            own_adr = m0_adr_i;
            own_dat = m0_dat_i;
            own_sel = m0_sel_i;
            own_we  = m0_we_i;
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
        end
    end

    // A stalled cycle is an owned strobe with no slave response; an ack or
    // err in the same cycle as the limit always beats the timeout.
    assign stall       = owning && own_cyc && own_stb && !s_ack_i && !s_err_i;
    assign bus_timeout = stall && (wait_cnt_q == TIMEOUT_CNT);
    assign drain_cyc   = last_grant_q ? m1_cyc_i : m0_cyc_i;

    // State, round-robin pointer and wait counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold grant while owner keeps cyc, drain after timeout
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    last_grant_d = ~last_grant_q;
                    state_d      = last_grant_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    last_grant_d = 1'b0;
                    state_d      = ST_OWN0;
                end else if (m1_cyc_i) begin
                    last_grant_d = 1'b1;
                    state_d      = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (bus_timeout) begin
                    state_d = ST_DRAIN;
                end else if (!own_cyc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!drain_cyc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Wait counter: counts consecutive stalled cycles, cleared on any response, idle strobe or state change
    always_comb begin
        wait_cnt_d = 16'd0;
        if ((state_d == state_q) && stall) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // Output routing: slave sees only the owner, responses return only to the owner
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_dat_o  = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = 2'b00;
        timeout_o = 1'b0;
        if (owning) begin
            s_adr_o   = own_adr;
            s_dat_o   = own_dat;
            s_sel_o   = own_sel;
            s_we_o    = own_we;
            s_cyc_o   = own_cyc && !bus_timeout;
            s_stb_o   = own_stb && !bus_timeout;
            timeout_o = bus_timeout;
            if (owner_is_m1) begin
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || bus_timeout;
                grant_o  = 2'b10;
            end else begin
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || bus_timeout;
                grant_o  = 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_wb_dmem_arbiter.sv
// tb/tb_wb_dmem_arbiter.sv - self-checking bench for wb_dmem_arbiter
module tb_wb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic            m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic            m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic            s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]      grant_o;
    logic            timeout_o;

    int errors = 0;
    int checks = 0;

    wb_dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Slave memory word observed at address 0x100
    logic [31:0] mem_100;
    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && s_we_o && s_ack_i && s_adr_o == 16'h0100)
            mem_100 <= s_dat_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic       rst;
        logic       m0c;
        logic       m1c;
        logic       ack;
        logic [7:0] exp;   // {grant, s_cyc, ack0, ack1, err0, err1, timeout}
    } vec_t;

    typedef struct packed {
        logic [AW-1:0]   adr;
        logic [DW-1:0]   dat;
        logic [DW/8-1:0] sel;
        logic            we, cyc, stb;
        logic [DW-1:0]   d0, d1;
        logic            a0, a1, e0, e1;
        logic [1:0]      g;
        logic            to;
    } obs_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic m0c, logic m1c, logic ack,
                                logic [1:0] g, logic scyc, logic a0, logic a1);
        vec_t v;
        v.rst = rst; v.m0c = m0c; v.m1c = m1c; v.ack = ack;
        v.exp = {g, scyc, a0, a1, 1'b0, 1'b0, 1'b0};
        return v;
    endfunction

    function automatic logic [7:0] short_obs();
        return {grant_o, s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o};
    endfunction

    function automatic obs_t full_obs();
        obs_t o;
        o.adr = s_adr_o; o.dat = s_dat_o; o.sel = s_sel_o;
        o.we = s_we_o; o.cyc = s_cyc_o; o.stb = s_stb_o;
        o.d0 = m0_dat_o; o.d1 = m1_dat_o;
        o.a0 = m0_ack_o; o.a1 = m1_ack_o; o.e0 = m0_err_o; o.e1 = m1_err_o;
        o.g = grant_o; o.to = timeout_o;
        return o;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1,
                         input logic ack, input logic err);
        m0_cyc_i = c0; m0_stb_i = s0;
        m1_cyc_i = c1; m1_stb_i = s1;
        s_ack_i = ack; s_err_i = err;
    endtask

    task automatic fixed_masters();
        m0_adr_i = 16'h0100; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF; m0_we_i = 1'b1;
        m1_adr_i = 16'h0200; m1_dat_i = 32'h11112222; m1_sel_i = 4'hF; m1_we_i = 1'b0;
        s_dat_i  = 32'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Reference model: who owns the bus, whether we are draining, and how long the owner has stalled
    int   mdl_owner;   // -1 none, else master index
    bit   mdl_drain;
    int   mdl_last;
    int   mdl_wait;
    bit   mdl_to;

    task automatic model_reset();
        mdl_owner = -1; mdl_drain = 0; mdl_last = 1; mdl_wait = 0; mdl_to = 0;
    endtask

    task automatic model_eval(output obs_t e);
        bit cyc, stb;
        e = '0;
        mdl_to = 0;
        if (mdl_owner >= 0 && !mdl_drain) begin
            cyc = (mdl_owner == 1) ? m1_cyc_i : m0_cyc_i;
            stb = (mdl_owner == 1) ? m1_stb_i : m0_stb_i;
            mdl_to = cyc && stb && !s_ack_i && !s_err_i && (mdl_wait == TO);
            e.adr = (mdl_owner == 1) ? m1_adr_i : m0_adr_i;
            e.dat = (mdl_owner == 1) ? m1_dat_i : m0_dat_i;
            e.sel = (mdl_owner == 1) ? m1_sel_i : m0_sel_i;
            e.we  = (mdl_owner == 1) ? m1_we_i  : m0_we_i;
            e.cyc = cyc && !mdl_to;
            e.stb = stb && !mdl_to;
            e.to  = mdl_to;
            if (mdl_owner == 0) begin
                e.d0 = s_dat_i; e.a0 = s_ack_i; e.e0 = s_err_i || mdl_to; e.g = 2'b01;
            end else begin
                e.d1 = s_dat_i; e.a1 = s_ack_i; e.e1 = s_err_i || mdl_to; e.g = 2'b10;
            end
        end
    endtask

    task automatic model_step();
        bit cyc, stb;
        if (mdl_drain) begin
            if (!((mdl_owner == 1) ? m1_cyc_i : m0_cyc_i)) begin
                mdl_owner = -1; mdl_drain = 0;
            end
        end else if (mdl_owner < 0) begin
            if (m0_cyc_i && m1_cyc_i) mdl_owner = 1 - mdl_last;
            else if (m0_cyc_i)        mdl_owner = 0;
            else if (m1_cyc_i)        mdl_owner = 1;
            if (mdl_owner >= 0) begin
                mdl_last = mdl_owner; mdl_wait = 0;
            end
        end else begin
            cyc = (mdl_owner == 1) ? m1_cyc_i : m0_cyc_i;
            stb = (mdl_owner == 1) ? m1_stb_i : m0_stb_i;
            if (mdl_to) begin
                mdl_drain = 1; mdl_wait = 0;
            end else if (!cyc) begin
                mdl_owner = -1; mdl_wait = 0;
            end else if (stb && !s_ack_i && !s_err_i) begin
                mdl_wait++;
            end else begin
                mdl_wait = 0;
            end
        end
    endtask

    initial begin
        obs_t e;
        bit c0, c1;
        reset_n = 1'b0;
        fixed_masters();
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_outputs", {full_obs()}, {obs_t'(0)});

        // Table: single m0 write acked on its second wait, then 8 tied requests after a fresh reset
        vecs.push_back(mk(1, 1, 0, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'b01, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 2'b01, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            logic w;
            w = k[0];
            vecs.push_back(mk(k == 0, 1, 1, 0, 2'b00, 0, 0, 0));
            vecs.push_back(mk(0, 1, 1, 1, w ? 2'b10 : 2'b01, 1, !w, w));
            vecs.push_back(mk(0, 0, 0, 0, w ? 2'b10 : 2'b01, 0, 0, 0));
        end
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].m0c, vecs[i].m0c, vecs[i].m1c, vecs[i].m1c, vecs[i].ack, 0);
            #4;
            chk($sformatf("vec[%0d]", i), {short_obs()}, {vecs[i].exp});
            tick();
        end
        chk("mem_0x100", {mem_100}, {32'hDEADBEEF});

        // m1 4-beat block read holds the bus against m0
        do_reset();
        drive(0, 0, 1, 1, 0, 0); #4;
        chk("blk_idle", {grant_o}, {2'b00}); tick();
        for (int b = 0; b < 4; b++) begin
            drive(1, 1, 1, 1, 1, 0);
            s_dat_i = 32'hA0000000 + b;
            #4;
            chk($sformatf("blk_beat%0d", b),
                {grant_o, m1_ack_o, m1_dat_o, m0_ack_o, m0_dat_o},
                {2'b10, 1'b1, 32'hA0000000 + b, 1'b0, 32'h0});
            tick();
        end
        s_dat_i = 32'h0;
        drive(1, 1, 1, 0, 0, 0); #4;
        chk("blk_gap", {grant_o, s_cyc_o}, {2'b10, 1'b1}); tick();
        drive(1, 1, 0, 0, 0, 0); #4;
        chk("blk_release", {grant_o, s_cyc_o}, {2'b10, 1'b0}); tick();
        #4; chk("blk_idle2", {grant_o}, {2'b00}); tick();
        #4; chk("blk_m0_grant", {grant_o, s_adr_o}, {2'b01, 16'h0100}); tick();
        drive(0, 0, 0, 0, 0, 0); tick(); tick();

        // Timeout with a slave that never answers, then DRAIN until m0 lets go
        do_reset();
        drive(1, 1, 0, 0, 0, 0); #4;
        chk("to_idle", {grant_o}, {2'b00}); tick();
        for (int w = 1; w <= TO; w++) begin
            #4;
            chk($sformatf("to_wait%0d", w), {grant_o, s_cyc_o, m0_err_o, timeout_o},
                {2'b01, 1'b1, 1'b0, 1'b0});
            tick();
        end
        #4;
        chk("to_fire", {grant_o, s_cyc_o, s_stb_o, m0_err_o, timeout_o, m1_err_o},
            {2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        tick();
        drive(1, 1, 0, 0, 1, 0); #4;
        chk("to_drain_late_ack", {grant_o, s_cyc_o, m0_ack_o, m0_err_o, timeout_o},
            {2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
        tick();
        drive(0, 0, 0, 0, 0, 0); #4;
        chk("to_drain_hold", {grant_o}, {2'b00}); tick();
        drive(0, 0, 1, 1, 0, 0); #4;
        chk("to_back_idle", {grant_o}, {2'b00}); tick();
        #4; chk("to_next_grant", {grant_o}, {2'b10}); tick();
        drive(0, 0, 0, 0, 0, 0); tick(); tick();

        // Ack arriving exactly at the timeout limit wins
        do_reset();
        drive(1, 1, 0, 0, 0, 0); tick();
        for (int w = 1; w <= TO; w++) tick();
        s_ack_i = 1'b1; #4;
        chk("ack_vs_to", {m0_ack_o, m0_err_o, timeout_o, s_cyc_o}, {1'b1, 1'b0, 1'b0, 1'b1});
        tick();
        drive(0, 0, 0, 0, 0, 0); tick(); tick();

        // Reset pulse during an m1 wait aborts immediately; first tie afterwards goes to m0
        do_reset();
        drive(0, 0, 1, 1, 0, 0); tick();
        #4; chk("rst_own1", {grant_o, s_cyc_o}, {2'b10, 1'b1}); tick();
        #2; reset_n = 1'b0; s_ack_i = 1'b1; #1;
        chk("rst_async", {full_obs()}, {obs_t'(0)});
        tick();
        reset_n = 1'b1;
        drive(1, 1, 1, 1, 0, 0); #4;
        chk("rst_tie_idle", {grant_o}, {2'b00}); tick();
        #4; chk("rst_tie_m0", {grant_o}, {2'b01}); tick();
        drive(0, 0, 0, 0, 0, 0); tick(); tick();

        // m0 abandons its cycle before the ack; a late ack goes nowhere
        do_reset();
        drive(1, 1, 0, 0, 0, 0); tick();
        #4; chk("drop_own0", {grant_o, s_cyc_o}, {2'b01, 1'b1}); tick();
        drive(0, 0, 0, 0, 0, 0); #4;
        chk("drop_same_cycle", {grant_o, s_cyc_o}, {2'b01, 1'b0}); tick();
        s_ack_i = 1'b1; #4;
        chk("drop_late_ack", {grant_o, m0_ack_o, m1_ack_o}, {2'b00, 1'b0, 1'b0}); tick();
        s_ack_i = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        c0 = 0; c1 = 0;
        for (int i = 0; i < 3000; i++) begin
            c0 = c0 ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
            c1 = c1 ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
            m0_cyc_i = c0; m0_stb_i = c0 && ($urandom_range(3) != 0);
            m1_cyc_i = c1; m1_stb_i = c1 && ($urandom_range(3) != 0);
            m0_adr_i = 16'($urandom); m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
            m1_adr_i = 16'($urandom); m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
            s_dat_i = $urandom;
            s_ack_i = ($urandom_range(3) == 0);
            s_err_i = ($urandom_range(15) == 0);
            #4;
            model_eval(e);
            chk($sformatf("rand[%0d]", i), {full_obs()}, {e});
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_dmem_arbiter.md
WB_DMEM_ARBITER -- requirements
Module: wb_dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32: Wishbone address width.
REQ-002 The block SHALL have parameter DW, default 32: Wishbone data width; byte selects are DW/8 bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 255: maximum wait cycles for slave ack/err, range 1..65535.
REQ-004 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have ports m0_adr_i / m1_adr_i, input, AW: master address (m0 = core data port, m1 = secondary master).
REQ-007 The block SHALL have ports m0_dat_i / m1_dat_i, input, DW: master write data.
REQ-008 The block SHALL have ports m0_sel_i / m1_sel_i, input, DW/8: master byte selects.
REQ-009 The block SHALL have ports m0_we_i / m1_we_i, m0_cyc_i / m1_cyc_i and m0_stb_i / m1_stb_i, input, 1 each: master write enable, cycle and strobe.
REQ-010 The block SHALL have ports m0_dat_o / m1_dat_o, output, DW: read data returned to the master.
REQ-011 The block SHALL have ports m0_ack_o / m1_ack_o and m0_err_o / m1_err_o, output, 1 each: master acknowledge and error.
REQ-012 The block SHALL have ports s_adr_o (AW), s_dat_o (DW), s_sel_o (DW/8), s_we_o, s_cyc_o and s_stb_o (1 each), output: shared data-memory slave request.
REQ-013 The block SHALL have ports s_dat_i (DW), s_ack_i (1) and s_err_i (1), input: slave response.
REQ-014 The block SHALL have port grant_o, output, 2: one-hot current owner; 00 when idle.
REQ-015 The block SHALL have port timeout_o, output, 1: one-cycle pulse on a bus timeout.

Function
REQ-016 The block SHALL implement the states IDLE, OWN0, OWN1 and DRAIN.
REQ-017 In IDLE with exactly one cyc high, the block SHALL move to that master's OWN state on the next edge (1-cycle arbitration latency).
REQ-018 In IDLE with both cyc high, the block SHALL grant the master not granted last (round-robin) and SHALL update last_grant on every grant.
REQ-019 In OWNx, the block SHALL drive the slave outputs combinationally from master x, with s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i.
REQ-020 In IDLE and DRAIN, the block SHALL drive all slave outputs to 0.
REQ-021 The block SHALL route s_ack_i, s_err_i and s_dat_i only to the owning master; the non-owning master SHALL see ack = err = 0 and dat_o = 0.
REQ-022 The block SHALL hold the grant while the owner keeps cyc high, so that back-to-back and block cycles are never interleaved.
REQ-023 When the owner drops cyc (including before ack), the block SHALL drop s_cyc_o the same cycle and enter IDLE on the next edge.
REQ-024 When the owner releases and the other master requests in the same cycle, the block SHALL go to IDLE and grant the other master one cycle later.
REQ-025 A 16-bit wait counter SHALL increment each OWN cycle with stb high and ack = err = 0, and SHALL clear on ack, err, stb low or state exit.
REQ-026 When the wait counter equals TIMEOUT, the block SHALL, in that cycle, assert mx_err_o and timeout_o, force s_cyc_o and s_stb_o low, and enter DRAIN.
REQ-027 In DRAIN, the block SHALL hold until the former owner's cyc is low, then enter IDLE; a late s_ack_i/s_err_i in DRAIN SHALL be ignored.
REQ-028 A simultaneous s_ack_i and timeout SHALL be resolved in favour of the ack, with no err and no timeout_o.
REQ-029 grant_o SHALL be 01 in OWN0, 10 in OWN1 and 00 otherwise.

Reset
REQ-030 When reset_n is low, the block SHALL asynchronously force state = IDLE, last_grant = m1, wait counter = 0, grant_o = 00 and timeout_o = 0, with all slave outputs and master ack/err 0.
REQ-031 A reset asserted mid-transfer SHALL abort the transfer with no ack or err delivered; after release, the first tie SHALL go to m0.

Verification
REQ-032 The bench SHALL cover: m0 single write to adr 0x100 with data 0xDEADBEEF and slave ack at wait 2 -> grant_o = 01 one cycle after cyc, m0_ack_o for 1 cycle, mem[0x100] = 0xDEADBEEF.
REQ-033 The bench SHALL cover: m0 and m1 raising cyc in the same cycle after reset -> m0 served first; on the next simultaneous request m1 served; strict alternation over 8 ties.
REQ-034 The bench SHALL cover: m1 doing a 4-beat block read with cyc held while m0 requests -> no m0 access until m1 drops cyc; m0 granted 2 cycles after release.
REQ-035 The bench SHALL cover: TIMEOUT = 4 with the slave never acking -> m0_err_o and timeout_o high on the 5th wait cycle, s_cyc_o low the same cycle, DRAIN until m0 cyc low, then IDLE.
REQ-036 The bench SHALL cover: reset_n pulsed low during an OWN1 wait -> outputs 0 immediately, no ack; after release, a tie grants m0.
REQ-037 The bench SHALL cover: m0 dropping cyc before ack -> s_cyc_o low the same cycle, IDLE next cycle, and a late ack not forwarded to either master.
